// File: rtl/calc_arbiter.sv
// rtl/calc_arbiter.sv - two-requester arbiter/sequencer for one shared calculadora datapath
// Define CALC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module calc_arbiter #(
  parameter int CALC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic [1:0] modo0,
  input  logic [1:0] modo1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] res,
  output logic       busy,
  output logic [3:0] calc_a,
  output logic [3:0] calc_b,
  output logic [1:0] calc_modo,
  input  logic [3:0] calc_c
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int CW = $clog2(CALC_LAT + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          pick1;

`ifdef CALC_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  // last holds the previous winner's ID; on a tie the other requester is chosen
  logic last;
  assign pick1 = req1 & (~req0 | ~last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (state == IDLE && (req0 | req1)) begin
      last <= pick1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      res       <= 4'd0;
      busy      <= 1'b0;
      calc_a    <= 4'd0;
      calc_b    <= 4'd0;
      calc_modo <= 2'd0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner     <= pick1;
            calc_a    <= pick1 ? a1 : a0;
            calc_b    <= pick1 ? b1 : b0;
            calc_modo <= pick1 ? modo1 : modo0;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(CALC_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // calc_c is valid by the final wait cycle; capture it on the way out
          if (cnt == CW'(1)) begin
            res   <= calc_c;
            done0 <= ~owner;
            done1 <= owner;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// tb/tb_calc_arbiter.sv - directed bench for calc_arbiter with CALC_LAT=1 and CALC_LAT=3 instances
// Expectations follow CALC_ARB_FIXED_PRIO_EN when it is defined.
module tb_calc_arbiter;

`ifdef CALC_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic       r0, r1;
    logic [3:0] a0, b0;
    logic [1:0] m0;
    logic [3:0] a1, b1;
    logic [1:0] m1;
    int         w;
    logic [3:0] res;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req0, req1;
  logic [3:0] a0, a1, b0, b1;
  logic [1:0] modo0, modo1;

  logic       g0_1, g1_1, d0_1, d1_1, busy_1;
  logic [3:0] res_1, ca_1, cb_1, c_1;
  logic [1:0] cm_1;
  logic       g0_3, g1_3, d0_3, d1_3, busy_3;
  logic [3:0] res_3, ca_3, cb_3, c_3;
  logic [1:0] cm_3;

  int total = 0;
  int bad = 0;
  vec_t vt[7];

  calc_arbiter #(.CALC_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .modo0(modo0), .modo1(modo1),
    .gnt0(g0_1), .gnt1(g1_1), .done0(d0_1), .done1(d1_1), .res(res_1), .busy(busy_1),
    .calc_a(ca_1), .calc_b(cb_1), .calc_modo(cm_1), .calc_c(c_1)
  );

  calc_arbiter #(.CALC_LAT(3)) u3 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .modo0(modo0), .modo1(modo1),
    .gnt0(g0_3), .gnt1(g1_3), .done0(d0_3), .done1(d1_3), .res(res_3), .busy(busy_3),
    .calc_a(ca_3), .calc_b(cb_3), .calc_modo(cm_3), .calc_c(c_3)
  );

  // registered calculadora stub: c = (a + b) mod 16
  always @(posedge clk) begin
    c_1 <= ca_1 + cb_1;
    c_3 <= ca_3 + cb_3;
  end

  function automatic logic [18:0] outs(input int inst);
    if (inst == 3) return {g0_3, g1_3, d0_3, d1_3, busy_3, res_3, ca_3, cb_3, cm_3};
    return {g0_1, g1_1, d0_1, d1_1, busy_1, res_1, ca_1, cb_1, cm_1};
  endfunction

  function automatic vec_t mk(input logic r0, input logic r1,
                              input logic [3:0] xa0, input logic [3:0] xb0, input logic [1:0] xm0,
                              input logic [3:0] xa1, input logic [3:0] xb1, input logic [1:0] xm1,
                              input int w, input logic [3:0] r);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = xa0; v.b0 = xb0; v.m0 = xm0;
    v.a1 = xa1; v.b1 = xb1; v.m1 = xm1; v.w = w; v.res = r;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_op(input int inst, input vec_t v, input string tag);
    int lat, n, gn, gw, dn, dw, busy_bad, multi;
    logic [3:0] dres, ga, gb;
    logic [1:0] gm;
    logic [18:0] o;
    lat = (inst == 3) ? 3 : 1;
    n = 0; gn = -1; gw = -1; dn = -1; dw = -1; busy_bad = 0; multi = 0;
    dres = 4'd0; ga = 4'd0; gb = 4'd0; gm = 2'd0;
    @(posedge clk); #1;
    req0 = v.r0; req1 = v.r1;
    a0 = v.a0; b0 = v.b0; modo0 = v.m0;
    a1 = v.a1; b1 = v.b1; modo1 = v.m1;
    while (dn < 0 && n < lat + 10) begin
      @(negedge clk);
      n++;
      o = outs(inst);
      if ($countones(o[18:15]) > 1) multi++;
      if ((n >= 2) != o[14]) busy_bad++;
      if (o[18] | o[17]) begin
        if (gn < 0) begin
          gn = n; gw = o[17] ? 1 : 0;
          ga = o[9:6]; gb = o[5:2]; gm = o[1:0];
          req0 = 1'b0; req1 = 1'b0;
        end else begin
          multi++;
        end
      end
      if (o[16] | o[15]) begin
        dn = n; dw = o[15] ? 1 : 0; dres = o[13:10];
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check($sformatf("%s gnt_cycle", tag), gn, 2);
    check($sformatf("%s gnt_who", tag), gw, v.w);
    check($sformatf("%s calc_a", tag), ga, (v.w == 1) ? v.a1 : v.a0);
    check($sformatf("%s calc_b", tag), gb, (v.w == 1) ? v.b1 : v.b0);
    check($sformatf("%s calc_modo", tag), gm, (v.w == 1) ? v.m1 : v.m0);
    check($sformatf("%s done_cycle", tag), dn, 3 + lat);
    check($sformatf("%s done_who", tag), dw, v.w);
    check($sformatf("%s res", tag), dres, v.res);
    check($sformatf("%s busy_profile", tag), busy_bad, 0);
    check($sformatf("%s extra_pulses", tag), multi, 0);
    @(negedge clk);
    o = outs(inst);
    check($sformatf("%s idle_busy", tag), o[14], 0);
    check($sformatf("%s res_hold", tag), o[13:10], v.res);
  endtask

  initial begin
    int n, gn, nd, ng, found, dcount;
    int rr_who[4], rr_t[4], dn_who[4];
    logic [3:0] dn_res[4];

    vt[0] = mk(1, 0, 4'd3, 4'd5, 2'd0, 4'd0, 4'd0, 2'd0, 0, 4'd8);
    vt[1] = mk(1, 1, 4'd1, 4'd2, 2'd1, 4'd4, 4'd4, 2'd2, FIXED ? 0 : 1, FIXED ? 4'd3 : 4'd8);
    vt[2] = mk(1, 1, 4'd6, 4'd7, 2'd3, 4'd9, 4'd9, 2'd1, 0, 4'd13);
    vt[3] = mk(0, 1, 4'd0, 4'd0, 2'd0, 4'd15, 4'd1, 2'd3, 1, 4'd0);
    vt[4] = mk(1, 1, 4'd2, 4'd2, 2'd2, 4'd8, 4'd7, 2'd0, 0, 4'd4);
    vt[5] = mk(1, 0, 4'd15, 4'd15, 2'd1, 4'd3, 4'd3, 2'd2, 0, 4'd14);
    vt[6] = mk(1, 1, 4'd0, 4'd0, 2'd2, 4'd5, 4'd6, 2'd3, FIXED ? 0 : 1, FIXED ? 4'd0 : 4'd11);

    // reset held with both requests active
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    modo0 = 2'($urandom); modo1 = 2'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("reset outs lat1", int'(outs(1)), 0);
      check("reset outs lat3", int'(outs(3)), 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0; gn = -1;
    while (gn < 0 && n < 6) begin
      @(negedge clk);
      n++;
      if (g0_1 | g1_1) gn = n;
    end
    check("release gnt cycle", gn, 2);
    check("release gnt0", g0_1, 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (10) @(negedge clk);

    // table vectors on the CALC_LAT=1 instance
    do_reset();
    for (int i = 0; i < 7; i++) run_op(1, vt[i], $sformatf("vec%0d", i));

    // back-to-back contention with both requests held
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 4'd1; b0 = 4'd1; a1 = 4'd7; b1 = 4'd9; modo0 = 2'd0; modo1 = 2'd0;
    n = 0; ng = 0; nd = 0;
    while (nd < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if ((g0_1 | g1_1) && ng < 4) begin
        rr_who[ng] = g1_1 ? 1 : 0; rr_t[ng] = n; ng++;
      end
      if ((d0_1 | d1_1) && nd < 4) begin
        dn_who[nd] = d1_1 ? 1 : 0; dn_res[nd] = res_1; nd++;
      end
    end
    check("contend grant count", ng, 4);
    check("contend done count", nd, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check($sformatf("contend gnt%0d who", i), rr_who[i], FIXED ? 0 : (i % 2));
      if (i < nd) begin
        check($sformatf("contend done%0d who", i), dn_who[i], FIXED ? 0 : (i % 2));
        check($sformatf("contend done%0d res", i), dn_res[i], (FIXED || (i % 2 == 0)) ? 2 : 0);
      end
      if (i > 0 && i < ng) check($sformatf("contend gap%0d", i), rr_t[i] - rr_t[i-1], 4);
    end
    req0 = 1'b0;
    found = 0; n = 0;
    while (found == 0 && n < 12) begin
      @(negedge clk);
      n++;
      if (g1_1) found = 1;
    end
    check("req1 served after req0 drops", found, 1);
    req1 = 1'b0;
    repeat (8) @(negedge clk);

    // reset during WAIT on the CALC_LAT=3 instance
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
    found = 0; n = 0;
    while (found == 0 && n < 5) begin
      @(negedge clk);
      n++;
      if (g0_3) found = 1;
    end
    check("midrst gnt seen", found, 1);
    req0 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst outs lat3", int'(outs(3)), 0);
    check("midrst outs lat1", int'(outs(1)), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (d0_3 | d1_3) dcount++;
    end
    check("midrst no done", dcount, 0);
    run_op(3, mk(0, 1, 4'd0, 4'd0, 2'd0, 4'd15, 4'd15, 2'd2, 1, 4'd14), "lat3 a");
    run_op(3, mk(0, 1, 4'd0, 4'd0, 2'd0, 4'd4, 4'd9, 2'd1, 1, 4'd13), "lat3 b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
